wb_regfile: RTL and testbench
=============================

Name: wb_regfile

Overview:
- Writeback-stage consumer of the MEM/WB pipeline register outputs: selects the writeback value and commits it to a 32 x 64-bit integer register file.
- Serves the ID stage through two read ports with same-cycle write-through bypass.
- Exposes the selected writeback value for the forwarding unit, plus a debug read port and a writeback event counter.

Parameters:
- XLEN, 64, data width of registers and writeback datapath.
- NREG, 32, number of architectural registers; index width is log2(NREG).

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- Mem_to_Reg  in  1  1 selects Read_Data, 0 selects Mem_Address (ALU result)
- Reg_Write  in  1  writeback enable
- Read_Data  in  XLEN  load data from MEM/WB
- Mem_Address  in  XLEN  ALU result from MEM/WB
- rd  in  5  destination register index
- rs1  in  5  read port 1 index (ID stage)
- rs2  in  5  read port 2 index (ID stage)
- rs1_data  out  XLEN  read port 1 data
- rs2_data  out  XLEN  read port 2 data
- wb_data  out  XLEN  selected writeback value, combinational, for forwarding
- dbg_addr  in  5  debug read index
- dbg_data  out  XLEN  debug read data
- wb_count  out  64  number of cycles with Reg_Write=1 since reset

Behaviour:
- wb_data = Mem_to_Reg ? Read_Data : Mem_Address.
  - Purely combinational.
  - Valid regardless of Reg_Write.
- Write: on rising clk edge, if Reg_Write=1 and rd!=0, regs[rd] <= wb_data.
- x0 handling:
  - Writes to rd=0 are dropped.
  - Any read of index 0 returns 0 on every port, including the bypass path.
- Read ports rs1_data, rs2_data, dbg_data: combinational.
  - If index==0, return 0.
  - Else if Reg_Write=1 and rd==index, return wb_data (write-through bypass, no extra cycle).
  - Else return regs[index].
- Both read ports and the debug port may address the same register simultaneously; all return identical data.
- wb_count:
  - Increments by 1 on each rising edge with Reg_Write=1, including when rd=0.
  - Wraps from 2^64-1 to 0; no saturation.
- Latency:
  - Write committed at edge N is visible from regs after edge N.
  - Via bypass it is visible during the cycle preceding edge N.
- Reset:
  - reset_n=0 asynchronously clears all registers and wb_count to 0 without waiting for clk.
  - rs1_data, rs2_data and dbg_data then read 0 unless the bypass is active.
  - wb_data follows its inputs even during reset.
  - No write commits while reset_n=0.
  - First commit possible on the first rising edge after reset_n deasserts.
  - Reset asserted mid-operation discards any pending write of that cycle.
- Inputs are assumed stable around the edge; no internal handshake. MEM/WB holds values between edges.

Decomposition:
- Shared package, used by all pipeline stages:
  - XLEN and register-index width constants.
  - REG_X0 = 0.
  - Writeback-select encoding (WB_SEL_ALU=0, WB_SEL_MEM=1).
- One natural sub-module, reg_array:
  - NREG x XLEN storage with async clear and one synchronous write port.
  - Three combinational read ports.
- The bypass/x0 logic and wb_count stay in wb_regfile.

Test Plan:
- Reset: hold reset_n=0 mid-cycle with regs preloaded -> all regs read 0 immediately (no clk edge), wb_count=0.
- ALU writeback: Reg_Write=1, Mem_to_Reg=0, Mem_Address=0x1234_5678_9ABC_DEF0, rd=5, then one edge; next cycle rs1=5 -> rs1_data=0x123456789ABCDEF0, wb_count=1.
- Load writeback with bypass: Reg_Write=1, Mem_to_Reg=1, Read_Data=0xDEAD_BEEF, rd=7, rs2=7 in the same cycle -> rs2_data=0xDEADBEEF before the edge; regs[7]=0xDEADBEEF after it.
- x0 protection: Reg_Write=1, rd=0, Mem_Address=0xFF, Mem_to_Reg=0, with rs1=rs2=dbg_addr=0 -> all ports read 0 before and after the edge; wb_count still increments.
- Write disabled: Reg_Write=0, rd=3, Read_Data=0x55, rs1=3, with regs[3]=0x11 -> rs1_data=0x11 and unchanged after the edge; wb_count unchanged.
- Counter wrap: force wb_count=0xFFFF_FFFF_FFFF_FFFF, one edge with Reg_Write=1 -> wb_count=0.

Source files
------------

// File: rtl/wb_regfile_pkg.sv
// Constants and encodings shared by the pipeline stages that touch the
// integer register file.
package wb_regfile_pkg;

    localparam int XLEN  = 64;
    localparam int NREG  = 32;
    localparam int IDX_W = $clog2(NREG);

    localparam logic [IDX_W-1:0] REG_X0 = '0;

    typedef enum logic {
        WB_SEL_ALU = 1'b0,
        WB_SEL_MEM = 1'b1
    } wb_sel_e;

    // Resolves one architectural read: x0 is hardwired to zero, and a
    // same-cycle write to the addressed register is forwarded through.
    function automatic logic [XLEN-1:0] resolve_read(
        input logic [IDX_W-1:0] idx,
        input logic             wr_en,
        input logic [IDX_W-1:0] wr_idx,
        input logic [XLEN-1:0]  wr_data,
        input logic [XLEN-1:0]  stored
    );
        if (idx == REG_X0)
            return '0;
        else if (wr_en && (wr_idx == idx))
            return wr_data;
        else
            return stored;
    endfunction

endpackage

// File: rtl/wb_regfile_reg_array.sv
// NREG x XLEN storage: asynchronous clear, one synchronous write port and
// three combinational read ports.
module wb_regfile_reg_array
    import wb_regfile_pkg::*;
(
    input  logic             clk,
    input  logic             reset_n,
    input  logic             we_i,
    input  logic [IDX_W-1:0] waddr_i,
    input  logic [XLEN-1:0]  wdata_i,
    input  logic [IDX_W-1:0] raddr_i [3],
    output logic [XLEN-1:0]  rdata_o [3]
);

    logic [XLEN-1:0] regs_q [NREG];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NREG; i++)
                regs_q[i] <= '0;
        end else if (we_i) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    for (genvar gi = 0; gi < 3; gi++) begin : g_rd
        assign rdata_o[gi] = regs_q[raddr_i[gi]];
    end

endmodule

// File: rtl/wb_regfile.sv
// Writeback stage: selects the writeback value, commits it to the register
// file, serves ID-stage/debug reads with write-through bypass, counts commits.
module wb_regfile
    import wb_regfile_pkg::*;
(
    input  logic             clk,
    input  logic             reset_n,
    input  logic             Mem_to_Reg,
    input  logic             Reg_Write,
    input  logic [XLEN-1:0]  Read_Data,
    input  logic [XLEN-1:0]  Mem_Address,
    input  logic [IDX_W-1:0] rd,
    input  logic [IDX_W-1:0] rs1,
    input  logic [IDX_W-1:0] rs2,
    output logic [XLEN-1:0]  rs1_data,
    output logic [XLEN-1:0]  rs2_data,
    output logic [XLEN-1:0]  wb_data,
    input  logic [IDX_W-1:0] dbg_addr,
    output logic [XLEN-1:0]  dbg_data,
    output logic [63:0]      wb_count
);

    logic [IDX_W-1:0] raddr  [3];
    logic [XLEN-1:0]  stored [3];
    logic [XLEN-1:0]  rport  [3];
    logic             array_we;
    logic [63:0]      wb_count_q;
    logic [63:0]      wb_count_d;

    assign wb_data  = (wb_sel_e'(Mem_to_Reg) == WB_SEL_MEM) ? Read_Data : Mem_Address;
    assign array_we = Reg_Write && (rd != REG_X0);

    assign raddr[0] = rs1;
    assign raddr[1] = rs2;
    assign raddr[2] = dbg_addr;

    wb_regfile_reg_array u_reg_array (
        .clk     (clk),
        .reset_n (reset_n),
        .we_i    (array_we),
        .waddr_i (rd),
        .wdata_i (wb_data),
        .raddr_i (raddr),
        .rdata_o (stored)
    );

    // The bypass uses the raw Reg_Write, so it stays live during reset.
    for (genvar gi = 0; gi < 3; gi++) begin : g_port
        assign rport[gi] = resolve_read(raddr[gi], Reg_Write, rd, wb_data, stored[gi]);
    end

    assign rs1_data = rport[0];
    assign rs2_data = rport[1];
    assign dbg_data = rport[2];

    // Counts every enabled writeback, including discarded x0 writes.
    always_comb begin
        wb_count_d = wb_count_q;
        if (Reg_Write)
            wb_count_d = wb_count_q + 64'd1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            wb_count_q <= '0;
        else
            wb_count_q <= wb_count_d;
    end

    assign wb_count = wb_count_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile: stimulus pushes expected port values into a
// scoreboard queue; a monitor pops and compares them mid-cycle.
module tb_wb_regfile;

    logic        clk;
    logic        reset_n;
    logic        Mem_to_Reg;
    logic        Reg_Write;
    logic [63:0] Read_Data;
    logic [63:0] Mem_Address;
    logic [4:0]  rd, rs1, rs2, dbg_addr;
    logic [63:0] rs1_data, rs2_data, wb_data, dbg_data, wb_count;

    localparam int P_RS1 = 0, P_RS2 = 1, P_WB = 2, P_DBG = 3, P_CNT = 4;

    typedef struct {
        int          port;
        logic [63:0] exp;
        string       name;
    } chk_t;

    chk_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    wb_regfile dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .Mem_to_Reg  (Mem_to_Reg),
        .Reg_Write   (Reg_Write),
        .Read_Data   (Read_Data),
        .Mem_Address (Mem_Address),
        .rd          (rd),
        .rs1         (rs1),
        .rs2         (rs2),
        .rs1_data    (rs1_data),
        .rs2_data    (rs2_data),
        .wb_data     (wb_data),
        .dbg_addr    (dbg_addr),
        .dbg_data    (dbg_data),
        .wb_count    (wb_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] port_val(input int p);
        case (p)
            P_RS1:   return rs1_data;
            P_RS2:   return rs2_data;
            P_WB:    return wb_data;
            P_DBG:   return dbg_data;
            default: return wb_count;
        endcase
    endfunction

    // Monitor: the read ports are combinational, so outputs are presented
    // every cycle; sample on the falling edge, away from the commit edge.
    always @(negedge clk) begin
        while (sb_q.size() > 0) begin
            chk_t c;
            logic [63:0] act;
            c   = sb_q.pop_front();
            act = port_val(c.port);
            n_checks++;
            if (act !== c.exp) begin
                n_errors++;
                $display("FAIL %s: got 0x%016h expected 0x%016h", c.name, act, c.exp);
            end else begin
                $display("ok   %s: 0x%016h", c.name, act);
            end
        end
    end

    task automatic expect_port(input int p, input logic [63:0] v, input string nm);
        chk_t c;
        c.port = p;
        c.exp  = v;
        c.name = nm;
        sb_q.push_back(c);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic rw, input logic m2r, input logic [63:0] rdat,
                         input logic [63:0] addr, input logic [4:0] d,
                         input logic [4:0] s1, input logic [4:0] s2, input logic [4:0] dbg);
        Reg_Write   = rw;
        Mem_to_Reg  = m2r;
        Read_Data   = rdat;
        Mem_Address = addr;
        rd          = d;
        rs1         = s1;
        rs2         = s2;
        dbg_addr    = dbg;
    endtask

    initial begin
        reset_n = 1'b0;
        drive(1'b0, 1'b0, 64'h0, 64'h0, 5'd0, 5'd5, 5'd7, 5'd3);

        // Power-on reset state
        #1;
        expect_port(P_RS1, 64'h0, "reset_rs1");
        expect_port(P_CNT, 64'h0, "reset_count");
        next_cycle();
        reset_n = 1'b1;

        // ALU writeback to x5
        next_cycle();
        drive(1'b1, 1'b0, 64'h0, 64'h1234_5678_9ABC_DEF0, 5'd5, 5'd0, 5'd0, 5'd0);
        expect_port(P_WB, 64'h1234_5678_9ABC_DEF0, "alu_wb_data");
        next_cycle();
        drive(1'b0, 1'b0, 64'h0, 64'h0, 5'd5, 5'd5, 5'd0, 5'd5);
        expect_port(P_RS1, 64'h1234_5678_9ABC_DEF0, "alu_rs1_after");
        expect_port(P_DBG, 64'h1234_5678_9ABC_DEF0, "alu_dbg_after");
        expect_port(P_CNT, 64'd1, "alu_count");

        // Load writeback to x7 with same-cycle bypass on rs2
        next_cycle();
        drive(1'b1, 1'b1, 64'hDEAD_BEEF, 64'h42, 5'd7, 5'd5, 5'd7, 5'd0);
        expect_port(P_RS2, 64'hDEAD_BEEF, "load_bypass_rs2");
        expect_port(P_WB,  64'hDEAD_BEEF, "load_wb_data");
        expect_port(P_RS1, 64'h1234_5678_9ABC_DEF0, "load_rs1_other");
        next_cycle();
        drive(1'b0, 1'b1, 64'h0, 64'h0, 5'd7, 5'd0, 5'd7, 5'd7);
        expect_port(P_RS2, 64'hDEAD_BEEF, "load_rs2_after");
        expect_port(P_DBG, 64'hDEAD_BEEF, "load_dbg_after");
        expect_port(P_CNT, 64'd2, "load_count");

        // x0 protection: write is dropped but counted
        next_cycle();
        drive(1'b1, 1'b0, 64'h0, 64'hFF, 5'd0, 5'd0, 5'd0, 5'd0);
        expect_port(P_RS1, 64'h0, "x0_rs1_before");
        expect_port(P_RS2, 64'h0, "x0_rs2_before");
        expect_port(P_DBG, 64'h0, "x0_dbg_before");
        expect_port(P_WB,  64'hFF, "x0_wb_data");
        next_cycle();
        drive(1'b1, 1'b1, 64'h11, 64'h0, 5'd3, 5'd0, 5'd0, 5'd0);
        expect_port(P_RS1, 64'h0, "x0_rs1_after");
        expect_port(P_DBG, 64'h0, "x0_dbg_after");
        expect_port(P_CNT, 64'd3, "x0_count");

        // Write disabled: x3 holds 0x11, no bypass while Reg_Write=0
        next_cycle();
        drive(1'b0, 1'b1, 64'h55, 64'h0, 5'd3, 5'd3, 5'd0, 5'd0);
        expect_port(P_RS1, 64'h11, "nowr_rs1_before");
        expect_port(P_CNT, 64'd4, "nowr_count_before");
        next_cycle();
        expect_port(P_RS1, 64'h11, "nowr_rs1_after");
        expect_port(P_CNT, 64'd4, "nowr_count_after");

        // All three ports on one register, with a bypass on another
        next_cycle();
        drive(1'b1, 1'b0, 64'h0, 64'hABC, 5'd9, 5'd7, 5'd7, 5'd7);
        expect_port(P_RS1, 64'hDEAD_BEEF, "same_rs1");
        expect_port(P_RS2, 64'hDEAD_BEEF, "same_rs2");
        expect_port(P_DBG, 64'hDEAD_BEEF, "same_dbg");
        next_cycle();
        drive(1'b0, 1'b0, 64'h0, 64'h0, 5'd9, 5'd9, 5'd7, 5'd0);
        expect_port(P_RS1, 64'hABC, "x9_rs1_after");
        expect_port(P_CNT, 64'd5, "x9_count");

        // Mid-cycle async reset with a pending write to x5
        next_cycle();
        drive(1'b1, 1'b0, 64'h0, 64'h777, 5'd5, 5'd5, 5'd7, 5'd9);
        #1;
        reset_n = 1'b0;
        expect_port(P_RS1, 64'h777, "rst_bypass_rs1");
        expect_port(P_RS2, 64'h0, "rst_rs2_cleared");
        expect_port(P_DBG, 64'h0, "rst_dbg_cleared");
        expect_port(P_CNT, 64'h0, "rst_count_cleared");
        expect_port(P_WB,  64'h777, "rst_wb_data");
        next_cycle();
        drive(1'b0, 1'b0, 64'h0, 64'h0, 5'd5, 5'd5, 5'd0, 5'd0);
        reset_n = 1'b1;
        expect_port(P_RS1, 64'h0, "rst_write_discarded");
        expect_port(P_CNT, 64'h0, "rst_count_held");

        // Counter wrap
        next_cycle();
        force dut.wb_count_q = 64'hFFFF_FFFF_FFFF_FFFF;
        #1;
        release dut.wb_count_q;
        Reg_Write = 1'b1;
        rd        = 5'd0;
        expect_port(P_CNT, 64'hFFFF_FFFF_FFFF_FFFF, "wrap_count_max");
        next_cycle();
        Reg_Write = 1'b0;
        expect_port(P_CNT, 64'h0, "wrap_count_zero");

        // Let the monitor drain, bounded
        for (int i = 0; i < 4 && sb_q.size() > 0; i++)
            @(posedge clk);
        @(posedge clk);
        if (sb_q.size() != 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL drain: %0d checks left, expected 0", sb_q.size());
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
